// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the core's word-wide data-memory interface.
// Formats byte/half/word loads with sign/zero extension and performs read-modify-write
// for sub-word stores. The memory has a registered read address, so read data arrives
// one cycle after the address edge.
// Optional feature: define LSU_MISALIGN_CHECK_EN to reject misaligned half/word accesses
// with err=1 instead of silently aligning them down.
module load_store_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  is_store,
  input  logic [2:0]            funct3,
  input  logic [31:0]           addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  ready,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  // Byte address bits that matter: word address plus the two lane bits.
  localparam int unsigned AW = ADDR_WIDTH + 2;

  typedef enum logic [2:0] {StIdle, StLdAddr, StLdCap, StRmwAddr, StRmwMrg, StStWr} state_e;

  state_e                state_q, state_d;
  logic [AW-1:0]         addr_q, addr_d, addr_in;
  logic [2:0]            funct3_q, funct3_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  done_q, done_d;
  logic                  accept, bad_in, in_half, in_word;
  logic [7:0]            lane_b;
  logic [15:0]           lane_h;
  logic [DATA_WIDTH-1:0] load_ext, merged;

  // Upper address bits fall outside the memory and are deliberately dropped.
  logic unused_addr;
  assign unused_addr = ^addr[31:AW];

  assign in_half = (funct3[1:0] == 2'b01);
  assign in_word = funct3[1];
  assign accept  = req && (state_q == StIdle);

`ifdef LSU_MISALIGN_CHECK_EN
  logic err_q, err_d;

  assign bad_in = (in_half && addr[0]) || (in_word && (addr[1:0] != 2'b00));
  assign err_d  = accept && bad_in;
  assign err    = err_q;

  // Error flag register, pulses together with done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
`else
  assign bad_in = 1'b0;
  assign err    = 1'b0;
`endif

  // Force the offset bits of halves and words to their natural alignment
  always_comb begin
    addr_in = addr[AW-1:0];
    if (in_half) addr_in[0]   = 1'b0;
    if (in_word) addr_in[1:0] = 2'b00;
  end

  // Lane extraction for loads and lane merge for sub-word stores
  always_comb begin
    lane_b = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    lane_h = mem_rdata[{addr_q[1], 4'b0000} +: 16];
    case (funct3_q[1:0])
      2'b00:   load_ext = {{24{~funct3_q[2] & lane_b[7]}}, lane_b};
      2'b01:   load_ext = {{16{~funct3_q[2] & lane_h[15]}}, lane_h};
      default: load_ext = mem_rdata;
    endcase
    merged = mem_rdata;
    if (funct3_q[1:0] == 2'b00) merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else                        merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept && !bad_in) begin
          if (!is_store)    state_d = StLdAddr;
          else if (in_word) state_d = StStWr;
          else              state_d = StRmwAddr;
        end
      end
      StLdAddr:  state_d = StLdCap;
      StLdCap:   state_d = StIdle;
      StRmwAddr: state_d = StRmwMrg;
      StRmwMrg:  state_d = StStWr;
      StStWr:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Output decode
  always_comb begin
    ready  = 1'b0;
    mem_re = 1'b0;
    mem_we = 1'b0;
    unique case (state_q)
      StIdle:                                 ready  = 1'b1;
      StLdAddr, StLdCap, StRmwAddr, StRmwMrg: mem_re = 1'b1;
      StStWr:                                 mem_we = 1'b1;
      default:                                ready  = 1'b0;
    endcase
  end

  assign mem_addr  = addr_q[AW-1:2];
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;
  assign done      = done_q;

  // Operand latching, merge capture, load capture and completion pulse
  always_comb begin
    addr_d   = addr_q;
    funct3_d = funct3_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    done_d   = (state_q == StLdCap) || (state_q == StStWr) || (accept && bad_in);
    if (accept && !bad_in) begin
      addr_d   = addr_in;
      funct3_d = funct3;
      wdata_d  = wdata;
    end
    if (state_q == StRmwMrg) wdata_d = merged;
    if (state_q == StLdCap)  rdata_d = load_ext;
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      funct3_q <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit with a registered-read word memory.
module tb_load_store_unit;

  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic          is_store = 1'b0;
  logic [2:0]    funct3 = 3'b0;
  logic [31:0]   addr = 32'h0;
  logic [31:0]   wdata = 32'h0;
  logic          ready, done, err, mem_we, mem_re;
  logic [31:0]   rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  logic          preload = 1'b1;
  logic [31:0]   mem [256];

  int tests = 0;
  int fails = 0;

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .req(req), .is_store(is_store), .funct3(funct3), .addr(addr),
    .wdata(wdata), .ready(ready), .done(done), .err(err), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Word memory with registered read address
  always @(posedge clk) begin
    if (preload) begin
      mem[0] <= 32'h11223344;
      mem[2] <= 32'h00000000;
      mem[5] <= 32'h8899AABB;
      mem[6] <= 32'h00007F01;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One complete transaction; inputs are scrambled right after the accept edge
  task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output int lat, output int we_n,
                        output int re_n, output int both_n, output logic e,
                        output logic [AW-1:0] we_addr);
    @(negedge clk);
    req = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
    @(posedge clk);
    #1;
    req = 1'b0; is_store = ~st; funct3 = 3'b111; addr = '1; wdata = '1;
    lat = -1; we_n = 0; re_n = 0; both_n = 0; e = 1'b0; we_addr = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done) begin
        lat = c;
        e = err;
        break;
      end
      if (mem_we) begin
        we_n++;
        we_addr = mem_addr;
      end
      if (mem_re) re_n++;
      if (mem_we && mem_re) both_n++;
    end
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp;  // load result, or memory word after a store
  } vec_t;

  vec_t          vecs [16];
  int            lat, we_n, re_n, both_n;
  logic          e;
  logic [AW-1:0] we_addr;
  logic [31:0]   exp_rd;
  int            exp_lat;

  initial begin
    vecs[0]  = '{1'b0, 3'b010, 32'h14, 32'h0,        32'h8899AABB};
    vecs[1]  = '{1'b0, 3'b000, 32'h16, 32'h0,        32'hFFFFFF99};
    vecs[2]  = '{1'b0, 3'b100, 32'h16, 32'h0,        32'h00000099};
    vecs[3]  = '{1'b0, 3'b001, 32'h16, 32'h0,        32'hFFFF8899};
    vecs[4]  = '{1'b0, 3'b101, 32'h14, 32'h0,        32'h0000AABB};
    vecs[5]  = '{1'b0, 3'b000, 32'h14, 32'h0,        32'hFFFFFFBB};
    vecs[6]  = '{1'b0, 3'b100, 32'h17, 32'h0,        32'h00000088};
    vecs[7]  = '{1'b1, 3'b000, 32'h15, 32'h123456CC, 32'h8899CCBB};
    vecs[8]  = '{1'b0, 3'b010, 32'h14, 32'h0,        32'h8899CCBB};
    vecs[9]  = '{1'b1, 3'b001, 32'h1A, 32'h0000F00D, 32'hF00D7F01};
    vecs[10] = '{1'b0, 3'b001, 32'h1A, 32'h0,        32'hFFFFF00D};
    vecs[11] = '{1'b1, 3'b010, 32'hF0000008, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[12] = '{1'b0, 3'b010, 32'h08, 32'h0,        32'hDEADBEEF};
    vecs[13] = '{1'b1, 3'b100, 32'h0B, 32'h000000A5, 32'hA5ADBEEF};
    vecs[14] = '{1'b0, 3'b000, 32'h0B, 32'h0,        32'hFFFFFFA5};
    vecs[15] = '{1'b0, 3'b101, 32'h0A, 32'h0,        32'h0000A5AD};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    preload = 1'b0;
    check("rst_ready", {31'b0, ready}, 32'd1);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_mem_we_re", {30'b0, mem_we, mem_re}, 32'd0);
    check("rst_mem_addr", {24'b0, mem_addr}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0;

    // Table-driven loads and stores
    exp_rd = 32'h0;
    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].st, vecs[i].f3, vecs[i].a, vecs[i].wd, lat, we_n, re_n, both_n, e, we_addr);
      exp_lat = !vecs[i].st ? 2 : (vecs[i].f3[1] ? 1 : 3);
      check($sformatf("v%0d_latency", i), lat, exp_lat);
      check($sformatf("v%0d_err", i), {31'b0, e}, 32'd0);
      check($sformatf("v%0d_we_cycles", i), we_n, vecs[i].st ? 1 : 0);
      check($sformatf("v%0d_re_cycles", i), re_n, (vecs[i].st && vecs[i].f3[1]) ? 0 : 2);
      check($sformatf("v%0d_we_re_excl", i), both_n, 0);
      check($sformatf("v%0d_ready_in_done", i), {31'b0, ready}, 32'd1);
      if (vecs[i].st) begin
        check($sformatf("v%0d_we_addr", i), {24'b0, we_addr}, {26'b0, vecs[i].a[7:2]});
        check($sformatf("v%0d_mem_word", i), mem[vecs[i].a[9:2]], vecs[i].exp);
      end else begin
        exp_rd = vecs[i].exp;
      end
      check($sformatf("v%0d_rdata", i), rdata, exp_rd);
    end

    // Word store with req held high: accepted again in the done cycle
    @(negedge clk);
    req = 1'b1; is_store = 1'b1; funct3 = 3'b010; addr = 32'h08; wdata = 32'h0BADF00D;
    @(posedge clk);
    @(negedge clk);
    check("b2b_we1", {31'b0, mem_we}, 32'd1);
    check("b2b_addr1", {24'b0, mem_addr}, 32'd2);
    check("b2b_wdata1", mem_wdata, 32'h0BADF00D);
    @(posedge clk);
    @(negedge clk);
    check("b2b_done1", {30'b0, done, ready}, 32'd3);
    check("b2b_we_off", {31'b0, mem_we}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("b2b_reaccept", {30'b0, ready, mem_we}, 32'd1);
    req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("b2b_done2", {31'b0, done}, 32'd1);
    check("b2b_mem", mem[2], 32'h0BADF00D);

    // Misaligned half load
    run_op(1'b0, 3'b001, 32'h15, 32'h0, lat, we_n, re_n, both_n, e, we_addr);
`ifdef LSU_MISALIGN_CHECK_EN
    check("mis_latency", lat, 0);
    check("mis_err", {31'b0, e}, 32'd1);
    check("mis_re_cycles", re_n, 0);
    check("mis_rdata", rdata, exp_rd);
`else
    check("mis_latency", lat, 2);
    check("mis_err", {31'b0, e}, 32'd0);
    check("mis_re_cycles", re_n, 2);
    check("mis_rdata", rdata, 32'hFFFFCCBB);
`endif

    // Reset during RMW_MRG of a half store aborts it cleanly
    @(negedge clk);
    req = 1'b1; is_store = 1'b1; funct3 = 3'b001; addr = 32'h02; wdata = 32'h0000BEEF;
    @(posedge clk);
    #1;
    req = 1'b0;
    @(posedge clk);
    #1;
    check("abort_in_mrg", {30'b0, mem_re, ready}, 32'd2);
    rst = 1'b1;
    #1;
    check("abort_ready", {31'b0, ready}, 32'd1);
    check("abort_outs", {29'b0, done, mem_we, mem_re}, 32'd0);
    check("abort_rdata", rdata, 32'h0);
    check("abort_mem_addr", {24'b0, mem_addr}, 32'd0);
    check("abort_mem_wdata", mem_wdata, 32'h0);
    we_n = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (mem_we || done) we_n++;
      if (c == 1) rst = 1'b0;
    end
    check("abort_no_we_done", we_n, 0);
    check("abort_mem_word", mem[0], 32'h11223344);
    run_op(1'b0, 3'b010, 32'h00, 32'h0, lat, we_n, re_n, both_n, e, we_addr);
    check("abort_reload", rdata, 32'h11223344);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the core's data-memory interface. Accepts one load or store request at a time from the execute stage and handles RISC-V byte/halfword/word formatting, including sign/zero extension. Drives the word-wide, single-write-enable data memory, which has a registered read address, and performs read-modify-write for sub-word stores. Signals completion with a one-cycle `done` pulse so the core can stall on `ready`.

## Interface
- `DATA_WIDTH`, 32, core and memory data width; only 32 is supported.
- `ADDR_WIDTH`, 8, memory word-address width; the memory depth is 2**ADDR_WIDTH words.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in 1: request valid; sampled only while `ready`=1.
- `is_store` in 1: 1 for a store, 0 for a load.
- `funct3` in 3: RISC-V width/sign code.
- `addr` in 32: byte address.
- `wdata` in 32: store data, right-aligned.
- `ready` out 1: unit idle; a request is accepted on an edge where `req`&&`ready`.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: misaligned-access flag; valid only with `done`.
- `rdata` out 32: formatted load result; held until the next load completes.
- `mem_addr` out ADDR_WIDTH: word address, `addr[ADDR_WIDTH+1:2]`.
- `mem_wdata` out 32: full word to write.
- `mem_we` out 1: memory write enable.
- `mem_re` out 1: memory read enable.
- `mem_rdata` in 32: memory read data, valid in the cycle after the address edge while `mem_re`=1.

## Operation
- FSM states: IDLE, LD_ADDR, LD_CAP, RMW_ADDR, RMW_MRG, ST_WR.
- On accept, the unit latches `addr`, `funct3`, `is_store` and `wdata`. Address bits above ADDR_WIDTH+1 are ignored.
- Size is taken from `funct3[1:0]`: 00 is a byte, 01 is a half, 1x is a word. `funct3[2]`=1 on a load selects zero extension. Store `funct3[2]` is ignored.
- Lanes are little-endian: byte k occupies bits [8k+7:8k].
- The lane is selected by `addr[1:0]` for bytes and by `addr[1]` for halves.
- Load path: IDLE→LD_ADDR→LD_CAP→IDLE.
  - `mem_re`=1 in LD_ADDR and in LD_CAP.
  - At the LD_CAP edge, `rdata` is loaded with the extended lane.
- Word store path: IDLE→ST_WR→IDLE. `mem_we`=1 and `mem_wdata`=`wdata` in ST_WR.
- Sub-word store path: IDLE→RMW_ADDR→RMW_MRG→ST_WR→IDLE.
  - `mem_re`=1 in RMW_ADDR and in RMW_MRG.
  - At the RMW_MRG edge, the merged word is registered: the `mem_rdata` word with only the target lane(s) replaced by `wdata[7:0]` or `wdata[15:0]`.
  - ST_WR then writes the merged word.
- `mem_we` and `mem_re` are never both 1 in the same cycle. Both are 0 in IDLE.
- `done`=1 in the cycle after leaving the final access state; the FSM is back in IDLE at that point.
- `err`=0 on every aligned access.

## Timing
- Reset values: state IDLE, `ready`=1, `done`=0, `err`=0, `rdata`=0, `mem_we`=0, `mem_re`=0, `mem_addr`=0, `mem_wdata`=0.
- Latency, counted from the accept edge E0 to the cycle in which `done`=1:
  - load: 2 edges (`done` in the cycle after E2);
  - word store: 1 edge;
  - sub-word store: 3 edges.
- `ready`=1 only in IDLE. A new request may be accepted on the edge that ends the `done` cycle, giving back-to-back operation.
- `req` while `ready`=0 is ignored and is not queued.
- Asserting `rst` mid-operation aborts the operation immediately:
  - no further `mem_we`;
  - `done` is not issued;
  - memory is unchanged if reset hits before ST_WR.
- Input changes after the accept edge have no effect, because all operands are latched.

## Configuration
- `LSU_MISALIGN_CHECK_EN` defined:
  - a half access with `addr[0]`=1, or a word access with `addr[1:0]`≠0, performs no memory access;
  - the FSM goes IDLE→IDLE with `done`=1 and `err`=1 in the next cycle;
  - `rdata` is unchanged and memory is untouched.
- `LSU_MISALIGN_CHECK_EN` undefined:
  - the low offset bits are forced to zero (half aligned to 2 bytes, word aligned to 4);
  - the access proceeds normally;
  - `err` is tied to 0.

## Test plan
- Word 5 preloaded with 0x8899AABB. LW at addr 0x14 → `done` 2 edges after accept, `rdata`=0x8899AABB, `mem_we` never asserted.
- Same word. LB at 0x16 → `rdata`=0xFFFFFF99. LBU at 0x16 → 0x00000099. LH at 0x16 → 0xFFFF8899. LHU at 0x14 → 0x0000AABB.
- SB of `wdata`=0x123456CC to 0x15 → exactly one `mem_we` cycle, `done` 3 edges after accept; a following LW returns 0x8899CCBB.
- SW of 0xDEADBEEF to 0x08 → `mem_we`=1 for one cycle with `mem_addr`=2, `done` next cycle. A `req` held high throughout is accepted again in the `done` cycle.
- LH at 0x15, with and without `LSU_MISALIGN_CHECK_EN`:
  - with: `done`=1 and `err`=1 one edge after accept, `mem_re` never 1;
  - without: returns the half at 0x14, `err`=0.
- SH to 0x02 with `rst` asserted during RMW_MRG → `mem_we` never asserted, outputs at reset values, memory word unchanged, `done` never pulses.
